dcache_bank_arb: RTL and testbench
==================================

// Module: dcache_bank_arb
// PURPOSE
//  Parametrised N-bank data-cache SRAM front end. Arbitrates each bank's RW port (port0)
//  between the memory-controller fill/writeback port (priority) and core stores. Core
//  stores that lose arbitration are parked in an in-order write queue instead of stalling
//  the core. Core loads use each bank's read-only port (port1). Read data is returned
//  through a bank-select pipeline matched to SRAM latency. Sits between Core/MemoryController and the MemRTL banks.
// PARAMETERS
//  NBANKS    2   number of banks, power of 2, >=2; BANK_W=$clog2(NBANKS)
//  IDX_W     9   word index bits per bank
//  DATA_W    32  word width; WM_W=DATA_W/8
//  WQ_DEPTH  4   core write-queue entries, >=1
//  RD_LAT    2   SRAM read latency in cycles, >=1
//  STARVE_LIM 8  head-of-queue wait cycles before guard acts (guard build only)
// PORTS (ADDR_W=BANK_W+IDX_W, word address)
//  clk            in  1             clock
//  rst            in  1             asynchronous reset, active-low
//  IN_mc_ce       in  1             MC request, active-low
//  IN_mc_we       in  1             MC write, active-low
//  IN_mc_wm       in  WM_W          MC byte mask
//  IN_mc_addr     in  ADDR_W        MC word address
//  IN_mc_data     in  DATA_W        MC write data
//  OUT_mc_data    out DATA_W        MC read data
//  OUT_mc_rvalid  out 1             MC read data valid
//  OUT_mc_stall   out 1             MC request refused this cycle (guard build only, else 0)
//  IN_cw_valid    in  1             core store valid
//  IN_cw_wm/addr/data in WM_W/ADDR_W/DATA_W  core store mask/address/data
//  OUT_cw_busy    out 1             store not accepted (queue full)
//  IN_cr_en       in  1             core load valid
//  IN_cr_addr     in  ADDR_W        core load address
//  OUT_cr_busy    out 1             load not accepted (hazard)
//  OUT_cr_data    out DATA_W        load data
//  OUT_cr_valid   out 1             load data valid
//  OUT_bank_nce0/nwe0 out NBANKS    per-bank port0 enables, active-low
//  OUT_bank_addr0 out NBANKS*IDX_W  port0 index; OUT_bank_wm0, OUT_bank_data0 per bank
//  IN_bank_data0  in  NBANKS*DATA_W port0 read data
//  OUT_bank_nce1  out NBANKS        port1 enable, active-low; OUT_bank_addr1, IN_bank_data1 per bank
// BEHAVIOUR
//  - bank=addr[BANK_W-1:0], index=addr[ADDR_W-1:BANK_W].
//  - Port0 owner per bank, per cycle: MC if !IN_mc_ce and bank matches; else queue head if
//    bank matches; else incoming store (bypass) if queue empty and bank matches; else idle (nce0=1).
//  - Store accept = IN_cw_valid && !OUT_cw_busy. Accepted store is written same cycle if
//    bypass wins, else enqueued at tail. Queue drains strictly in order, head only, max 1/cycle.
//  - OUT_cw_busy = (count==WQ_DEPTH), from registered count only; simultaneous dequeue
//    does not clear busy that cycle. Enqueue+dequeue same cycle: count unchanged.
//  - OUT_cr_busy=1 when IN_cr_en and IN_cr_addr equals any valid queue entry or the
//    accepted incoming store address (read-after-write guard). Otherwise load always accepted.
//  - Loads: OUT_cr_valid/OUT_cr_data exactly RD_LAT cycles after acceptance, data muxed by
//    RD_LAT-deep registered bank select. MC reads (ce=0,we=1): OUT_mc_rvalid/OUT_mc_data RD_LAT
//    cycles later from port0. Back-to-back every cycle supported on both.
//  - Same-cycle MC write and core load to the same word: load returns pre-write data.
//  - Reset (rst=0, async): queue emptied (pending stores discarded), count=0, pipelines
//    cleared; OUT_cw_busy=0, OUT_cr_busy=0, OUT_cr_valid=0, OUT_mc_rvalid=0, OUT_mc_stall=0,
//    OUT_cr_data=0, OUT_mc_data=0, all nce0/nce1/nwe0=1. In-flight reads produce no valid.
// CONFIGURATION
//  DCBANK_STARVE_GUARD_EN defined: head-age counter increments each cycle head is
//   present and not written, clears on dequeue. When age>=STARVE_LIM and MC targets head's
//   bank, head wins port0, OUT_mc_stall=1 that cycle; MC must hold its request unchanged.
//  Undefined: no counter, MC always wins, OUT_mc_stall tied 0.
// TESTING (NBANKS=2, IDX_W=9, DATA_W=32, WQ_DEPTH=4, RD_LAT=2)
//  store addr 0x004 data 0xDEADBEEF, no MC -> bank0 nce0=0,nwe0=0 same cycle; load 0x004 -> 0xDEADBEEF, valid 2 cycles later
//  MC writes bank1 for 6 cycles, core stores 5 words to bank1 -> 4 queued, busy on 5th; drain in order after MC idles
//  queued store addr 0x011, load 0x011 -> cr_busy=1 until dequeued, then returns stored data
//  loads 0x000,0x001,0x002 consecutive cycles -> valid 3 cycles in order, correct bank data each
//  rst=0 with 3 queued stores -> count=0, no bank writes after release, all outputs at reset values
//  guard build: MC holds bank0 20 cycles, store queued at 0x000 -> written cycle 9, mc_stall=1 that cycle only

Source files
------------

// File: rtl/dcache_bank_arb.sv
// dcache_bank_arb: N-bank data-cache SRAM front end.
//  port0 (RW) per bank: MC fill/writeback first, then the core write-queue head,
//  then a bypassing core store (only when the queue is empty).
//  port1 (RO) per bank: core loads.
//  Read data comes back through RD_LAT-deep registered bank-select pipes.
// Build option: define DCBANK_STARVE_GUARD_EN to let a queue head that has waited
//  STARVE_LIM cycles pre-empt the MC on its bank (MC sees OUT_mc_stall for that cycle).

// Per-bank port0 owner select and drive
module dcache_bank_port #(
  parameter int IDX_W  = 9,
  parameter int WM_W   = 4,
  parameter int DATA_W = 32
) (
  input  logic              mc_hit,
  input  logic              mc_nwe,
  input  logic [IDX_W-1:0]  mc_idx,
  input  logic [WM_W-1:0]   mc_wm,
  input  logic [DATA_W-1:0] mc_data,
  input  logic              hd_hit,
  input  logic [IDX_W-1:0]  hd_idx,
  input  logic [WM_W-1:0]   hd_wm,
  input  logic [DATA_W-1:0] hd_data,
  input  logic              by_hit,
  input  logic [IDX_W-1:0]  by_idx,
  input  logic [WM_W-1:0]   by_wm,
  input  logic [DATA_W-1:0] by_data,
  input  logic              starve,
  output logic              nce0,
  output logic              nwe0,
  output logic [IDX_W-1:0]  addr0,
  output logic [WM_W-1:0]   wm0,
  output logic [DATA_W-1:0] data0,
  output logic              gnt_hd,
  output logic              gnt_by,
  output logic              stall
);
  logic hd_force, gnt_mc;

  // an aged head takes the bank away from the MC
  assign hd_force = starve && hd_hit;
  assign stall    = hd_force && mc_hit;

  // Priority: forced head > MC > queue head > bypass store
  always_comb begin
    gnt_mc = 1'b0;
    gnt_hd = 1'b0;
    gnt_by = 1'b0;
    if (hd_force)    gnt_hd = 1'b1;
    else if (mc_hit) gnt_mc = 1'b1;
    else if (hd_hit) gnt_hd = 1'b1;
    else if (by_hit) gnt_by = 1'b1;
  end

  // Drive port0 from whichever requester won
  always_comb begin
    nce0  = 1'b1;
    nwe0  = 1'b1;
    addr0 = '0;
    wm0   = '0;
    data0 = '0;
    if (gnt_mc) begin
      nce0 = 1'b0; nwe0 = mc_nwe; addr0 = mc_idx; wm0 = mc_wm; data0 = mc_data;
    end else if (gnt_hd) begin
      nce0 = 1'b0; nwe0 = 1'b0; addr0 = hd_idx; wm0 = hd_wm; data0 = hd_data;
    end else if (gnt_by) begin
      nce0 = 1'b0; nwe0 = 1'b0; addr0 = by_idx; wm0 = by_wm; data0 = by_data;
    end
  end
endmodule

module dcache_bank_arb #(
  parameter int  NBANKS     = 2,
  parameter int  IDX_W      = 9,
  parameter int  DATA_W     = 32,
  parameter int  WQ_DEPTH   = 4,
  parameter int  RD_LAT     = 2,
  parameter int  STARVE_LIM = 8,
  localparam int BANK_W     = $clog2(NBANKS),
  localparam int ADDR_W     = BANK_W + IDX_W,
  localparam int WM_W       = DATA_W / 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           IN_mc_ce,
  input  logic                           IN_mc_we,
  input  logic [WM_W-1:0]                IN_mc_wm,
  input  logic [ADDR_W-1:0]              IN_mc_addr,
  input  logic [DATA_W-1:0]              IN_mc_data,
  output logic [DATA_W-1:0]              OUT_mc_data,
  output logic                           OUT_mc_rvalid,
  output logic                           OUT_mc_stall,
  input  logic                           IN_cw_valid,
  input  logic [WM_W-1:0]                IN_cw_wm,
  input  logic [ADDR_W-1:0]              IN_cw_addr,
  input  logic [DATA_W-1:0]              IN_cw_data,
  output logic                           OUT_cw_busy,
  input  logic                           IN_cr_en,
  input  logic [ADDR_W-1:0]              IN_cr_addr,
  output logic                           OUT_cr_busy,
  output logic [DATA_W-1:0]              OUT_cr_data,
  output logic                           OUT_cr_valid,
  output logic [NBANKS-1:0]              OUT_bank_nce0,
  output logic [NBANKS-1:0]              OUT_bank_nwe0,
  output logic [NBANKS-1:0][IDX_W-1:0]   OUT_bank_addr0,
  output logic [NBANKS-1:0][WM_W-1:0]    OUT_bank_wm0,
  output logic [NBANKS-1:0][DATA_W-1:0]  OUT_bank_data0,
  input  logic [NBANKS-1:0][DATA_W-1:0]  IN_bank_data0,
  output logic [NBANKS-1:0]              OUT_bank_nce1,
  output logic [NBANKS-1:0][IDX_W-1:0]   OUT_bank_addr1,
  input  logic [NBANKS-1:0][DATA_W-1:0]  IN_bank_data1
);
  localparam int CNT_W = $clog2(WQ_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WM_W-1:0]   wm;
    logic [DATA_W-1:0] data;
  } wreq_t;

  logic                     mc_req, mc_rd, mc_stall;
  logic                     cw_busy, cw_acc, deq, byp, enq;
  logic                     cr_req, cr_acc, cr_raw;
  logic                     hd_vld, starve;
  logic [BANK_W-1:0]        mc_bank, cw_bank, cr_bank, hd_bank;
  logic [NBANKS-1:0]        gnt_hd, gnt_by, stall_b;
  wreq_t                    cw_req;
  wreq_t                    q     [WQ_DEPTH];
  wreq_t                    q_nxt [WQ_DEPTH];
  logic [CNT_W-1:0]         count, count_nxt, wr_pos;
  logic [RD_LAT:1]              cr_vld_pipe, mc_vld_pipe;
  logic [RD_LAT:1][BANK_W-1:0]  cr_bsel_pipe, mc_bsel_pipe;

  // nothing is requested while reset is held, so every port idles at its reset value
  assign mc_req  = !IN_mc_ce && rst;
  assign cw_busy = (count == CNT_W'(WQ_DEPTH));
  assign cw_acc  = IN_cw_valid && !cw_busy && rst;
  assign cr_req  = IN_cr_en && rst;
  assign cr_acc  = cr_req && !cr_raw;

  assign mc_bank = IN_mc_addr[BANK_W-1:0];
  assign cw_bank = IN_cw_addr[BANK_W-1:0];
  assign cr_bank = IN_cr_addr[BANK_W-1:0];
  assign hd_bank = q[0].addr[BANK_W-1:0];
  assign hd_vld  = (count != '0);
  assign cw_req  = '{addr: IN_cw_addr, wm: IN_cw_wm, data: IN_cw_data};

  assign deq      = |gnt_hd;
  assign byp      = |gnt_by;
  assign enq      = cw_acc && !byp;
  assign mc_stall = |stall_b;
  assign mc_rd    = mc_req && IN_mc_we && !mc_stall;
  assign wr_pos   = count - CNT_W'(deq);
  assign count_nxt = count + CNT_W'(enq) - CNT_W'(deq);

  assign OUT_cw_busy  = cw_busy;
  assign OUT_cr_busy  = cr_req && cr_raw;
  assign OUT_mc_stall = mc_stall;

  // one port0 arbiter per bank, plus the load-port drive
  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    dcache_bank_port #(.IDX_W(IDX_W), .WM_W(WM_W), .DATA_W(DATA_W)) u_port (
      .mc_hit  (mc_req && (mc_bank == BANK_W'(b))),
      .mc_nwe  (IN_mc_we),
      .mc_idx  (IN_mc_addr[ADDR_W-1:BANK_W]),
      .mc_wm   (IN_mc_wm),
      .mc_data (IN_mc_data),
      .hd_hit  (hd_vld && (hd_bank == BANK_W'(b))),
      .hd_idx  (q[0].addr[ADDR_W-1:BANK_W]),
      .hd_wm   (q[0].wm),
      .hd_data (q[0].data),
      .by_hit  (cw_acc && !hd_vld && (cw_bank == BANK_W'(b))),
      .by_idx  (IN_cw_addr[ADDR_W-1:BANK_W]),
      .by_wm   (IN_cw_wm),
      .by_data (IN_cw_data),
      .starve  (starve),
      .nce0    (OUT_bank_nce0[b]),
      .nwe0    (OUT_bank_nwe0[b]),
      .addr0   (OUT_bank_addr0[b]),
      .wm0     (OUT_bank_wm0[b]),
      .data0   (OUT_bank_data0[b]),
      .gnt_hd  (gnt_hd[b]),
      .gnt_by  (gnt_by[b]),
      .stall   (stall_b[b])
    );
    assign OUT_bank_nce1[b]  = !(cr_acc && (cr_bank == BANK_W'(b)));
    assign OUT_bank_addr1[b] = IN_cr_addr[ADDR_W-1:BANK_W];
  end

  // Read-after-write guard: load blocked while its word sits in the queue or is being stored now
  always_comb begin
    cr_raw = cw_acc && (IN_cw_addr == IN_cr_addr);
    for (int i = 0; i < WQ_DEPTH; i++)
      if ((CNT_W'(i) < count) && (q[i].addr == IN_cr_addr)) cr_raw = 1'b1;
  end

  // Queue next state: shift out the head on dequeue, then write the new tail
  always_comb begin
    q_nxt = q;
    if (deq)
      for (int i = 0; i < WQ_DEPTH - 1; i++) q_nxt[i] = q[i + 1];
    for (int i = 0; i < WQ_DEPTH; i++)
      if (enq && (CNT_W'(i) == wr_pos)) q_nxt[i] = cw_req;
  end

  // Queue storage and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WQ_DEPTH; i++) q[i] <= '0;
      count <= '0;
    end else begin
      q     <= q_nxt;
      count <= count_nxt;
    end
  end

`ifdef DCBANK_STARVE_GUARD_EN
  localparam int AGE_W = $clog2(STARVE_LIM + 1);
  logic [AGE_W-1:0] age;

  // Cycles the current head has waited; saturates at the limit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          age <= '0;
    else if (deq || !hd_vld)           age <= '0;
    else if (age != AGE_W'(STARVE_LIM)) age <= age + 1'b1;
  end

  assign starve = (age >= AGE_W'(STARVE_LIM));
`else
  assign starve = 1'b0;
`endif

  // Valid / bank-select pipes matched to SRAM read latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cr_vld_pipe  <= '0;
      cr_bsel_pipe <= '0;
      mc_vld_pipe  <= '0;
      mc_bsel_pipe <= '0;
    end else begin
      cr_vld_pipe[1]  <= cr_acc;
      cr_bsel_pipe[1] <= cr_bank;
      mc_vld_pipe[1]  <= mc_rd;
      mc_bsel_pipe[1] <= mc_bank;
      for (int s = 2; s <= RD_LAT; s++) begin
        cr_vld_pipe[s]  <= cr_vld_pipe[s-1];
        cr_bsel_pipe[s] <= cr_bsel_pipe[s-1];
        mc_vld_pipe[s]  <= mc_vld_pipe[s-1];
        mc_bsel_pipe[s] <= mc_bsel_pipe[s-1];
      end
    end
  end

  assign OUT_cr_valid  = cr_vld_pipe[RD_LAT];
  assign OUT_cr_data   = cr_vld_pipe[RD_LAT] ? IN_bank_data1[cr_bsel_pipe[RD_LAT]] : '0;
  assign OUT_mc_rvalid = mc_vld_pipe[RD_LAT];
  assign OUT_mc_data   = mc_vld_pipe[RD_LAT] ? IN_bank_data0[mc_bsel_pipe[RD_LAT]] : '0;
endmodule

// File: tb/tb_dcache_bank_arb.sv
// Directed bench for dcache_bank_arb (2 banks, 9-bit index, 32-bit data, 4-deep queue, RD_LAT 2).
// Includes a behavioural two-port SRAM per bank: read-before-write, byte mask bit=1 writes.
module tb_dcache_bank_arb;
  localparam int NB = 2, IW = 9, DW = 32, WMW = 4, AW = 10;
`ifdef DCBANK_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic mc_ce, mc_we;
  logic [WMW-1:0] mc_wm, cw_wm;
  logic [AW-1:0]  mc_addr, cw_addr, cr_addr;
  logic [DW-1:0]  mc_data, cw_data, mc_rdata, cr_data;
  logic mc_rvalid, mc_stall, cw_valid, cw_busy, cr_en, cr_busy, cr_valid;
  logic [NB-1:0] nce0, nwe0, nce1;
  logic [NB-1:0][IW-1:0]  addr0, addr1;
  logic [NB-1:0][WMW-1:0] wm0;
  logic [NB-1:0][DW-1:0]  data0, brd0, brd1;

  int n_cmp = 0, n_bad = 0, wr_cnt = 0, wr_snap;
  logic mem_init;
  logic [DW-1:0] mem [NB][1<<IW];
  logic [DW-1:0] p0_s1 [NB], p0_s2 [NB], p1_s1 [NB], p1_s2 [NB];

  always #5 clk = ~clk;

  dcache_bank_arb #(.NBANKS(NB), .IDX_W(IW), .DATA_W(DW), .WQ_DEPTH(4), .RD_LAT(2), .STARVE_LIM(8)) dut (
    .clk(clk), .rst(rst),
    .IN_mc_ce(mc_ce), .IN_mc_we(mc_we), .IN_mc_wm(mc_wm), .IN_mc_addr(mc_addr), .IN_mc_data(mc_data),
    .OUT_mc_data(mc_rdata), .OUT_mc_rvalid(mc_rvalid), .OUT_mc_stall(mc_stall),
    .IN_cw_valid(cw_valid), .IN_cw_wm(cw_wm), .IN_cw_addr(cw_addr), .IN_cw_data(cw_data),
    .OUT_cw_busy(cw_busy),
    .IN_cr_en(cr_en), .IN_cr_addr(cr_addr), .OUT_cr_busy(cr_busy), .OUT_cr_data(cr_data), .OUT_cr_valid(cr_valid),
    .OUT_bank_nce0(nce0), .OUT_bank_nwe0(nwe0), .OUT_bank_addr0(addr0), .OUT_bank_wm0(wm0),
    .OUT_bank_data0(data0), .IN_bank_data0(brd0),
    .OUT_bank_nce1(nce1), .OUT_bank_addr1(addr1), .IN_bank_data1(brd1)
  );

  function automatic logic [DW-1:0] initv(input int b, input int i);
    return 32'h5A00_0000 | (b << 16) | i;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n, input logic [WMW-1:0] m);
    logic [DW-1:0] r;
    r = o;
    for (int k = 0; k < WMW; k++) if (m[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  // SRAM model: 2-cycle read on both ports, port1 sees pre-write data on a same-edge write
  always @(posedge clk) begin
    if (mem_init) begin
      for (int b = 0; b < NB; b++)
        for (int i = 0; i < (1 << IW); i++) mem[b][i] <= initv(b, i);
    end else begin
      for (int b = 0; b < NB; b++) begin
        p0_s1[b] <= mem[b][addr0[b]];
        p0_s2[b] <= p0_s1[b];
        p1_s1[b] <= mem[b][addr1[b]];
        p1_s2[b] <= p1_s1[b];
        if (!nce0[b] && !nwe0[b]) begin
          mem[b][addr0[b]] <= merge(mem[b][addr0[b]], data0[b], wm0[b]);
          wr_cnt <= wr_cnt + 1;
        end
      end
    end
  end

  always_comb begin
    brd0 = '0;
    brd1 = '0;
    for (int b = 0; b < NB; b++) begin
      brd0[b] = p0_s2[b];
      brd1[b] = p1_s2[b];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    mc_ce = 1'b1; mc_we = 1'b1; mc_wm = '0; mc_addr = '0; mc_data = '0;
    cw_valid = 1'b0; cw_wm = '0; cw_addr = '0; cw_data = '0;
    cr_en = 1'b0; cr_addr = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  int si;
  logic exp_busy;
  int head_cyc;

  initial begin
    rst = 1'b0; mem_init = 1'b1; idle_in();
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;

    // reset: requests presented while held must not reach the banks
    mc_ce = 1'b0; mc_we = 1'b0; mc_addr = 10'h004;
    cw_valid = 1'b1; cw_wm = 4'hF; cw_addr = 10'h004; cr_en = 1'b1; cr_addr = 10'h004;
    #2;
    chk("rst_cw_busy", cw_busy, 0); chk("rst_cr_busy", cr_busy, 0);
    chk("rst_cr_valid", cr_valid, 0); chk("rst_mc_rvalid", mc_rvalid, 0);
    chk("rst_mc_stall", mc_stall, 0); chk("rst_cr_data", cr_data, 0); chk("rst_mc_data", mc_rdata, 0);
    chk("rst_nce0", nce0, 2'b11); chk("rst_nwe0", nwe0, 2'b11); chk("rst_nce1", nce1, 2'b11);
    idle_in();
    nxt(); rst = 1'b1;

    // bypass store then load
    nxt(); cw_valid = 1'b1; cw_wm = 4'hF; cw_addr = 10'h004; cw_data = 32'hDEAD_BEEF; #2;
    chk("byp_nce0", nce0, 2'b10); chk("byp_nwe0", nwe0, 2'b10);
    chk("byp_addr0", addr0[0], 9'h002); chk("byp_data0", data0[0], 32'hDEAD_BEEF); chk("byp_busy", cw_busy, 0);
    nxt(); cw_valid = 1'b0; cr_en = 1'b1; cr_addr = 10'h004; #2;
    chk("ld_busy", cr_busy, 0); chk("ld_nce1", nce1, 2'b10); chk("ld_addr1", addr1[0], 9'h002);
    nxt(); cr_en = 1'b0; #2;
    chk("ld_valid_l1", cr_valid, 0);
    nxt(); #2;
    chk("ld_valid_l2", cr_valid, 1); chk("ld_data", cr_data, 32'hDEAD_BEEF);

    // back-to-back loads across banks
    for (int c = 0; c < 6; c++) begin
      nxt(); cr_en = (c < 3); cr_addr = AW'(c); #2;
      if (c < 3) chk("b2b_nce1", nce1, (c % 2) ? 2'b01 : 2'b10);
      chk("b2b_valid", cr_valid, (c >= 2 && c <= 4));
      if (c >= 2 && c <= 4) chk("b2b_data", cr_data, initv((c - 2) % 2, (c - 2) / 2));
    end

    // MC writes bank1 for 6 cycles while 5 stores target bank1
    si = 0;
    for (int c = 0; c < 12; c++) begin
      nxt(); idle_in();
      if (c < 6) begin
        mc_ce = 1'b0; mc_we = 1'b0; mc_wm = 4'hF; mc_addr = AW'(10'h101 + 2*c); mc_data = 32'h1111_0000 + c;
      end
      if (si < 5) begin
        cw_valid = 1'b1; cw_wm = 4'hF; cw_addr = AW'(10'h021 + 2*si); cw_data = 32'hC000_0000 + si;
      end
      exp_busy = (c >= 4 && c <= 6);
      #2;
      chk("q_mc_stall", mc_stall, 0);
      if (c < 8) chk("q_cw_busy", cw_busy, exp_busy);
      chk("q_nce0", nce0, (c <= 10) ? 2'b01 : 2'b11);
      if (c <= 10) chk("q_nwe0", nwe0, 2'b01);
      if (c < 6) begin
        chk("q_mc_addr0", addr0[1], 9'h080 + c); chk("q_mc_data0", data0[1], 32'h1111_0000 + c);
      end else if (c <= 10) begin
        chk("q_drain_addr0", addr0[1], 9'h010 + (c - 6)); chk("q_drain_data0", data0[1], 32'hC000_0000 + (c - 6));
      end
      if (si < 5 && !exp_busy) si++;
    end
    nxt(); cr_en = 1'b1; cr_addr = 10'h101; #2;
    nxt(); cr_addr = 10'h029; #2;
    nxt(); cr_en = 1'b0; #2;
    chk("mcw_valid", cr_valid, 1); chk("mcw_data", cr_data, 32'h1111_0000);
    nxt(); #2;
    chk("st5_valid", cr_valid, 1); chk("st5_data", cr_data, 32'hC000_0004);

    // RAW guard on a queued store
    for (int c = 0; c < 6; c++) begin
      nxt(); idle_in();
      if (c < 2) begin mc_ce = 1'b0; mc_we = 1'b0; mc_wm = 4'hF; mc_addr = 10'h0FF; mc_data = 32'h0BAD_0000; end
      if (c == 0) begin cw_valid = 1'b1; cw_wm = 4'hF; cw_addr = 10'h011; cw_data = 32'h1234_5678; end
      if (c <= 3) begin cr_en = 1'b1; cr_addr = 10'h011; end
      #2;
      if (c <= 3) chk("raw_busy", cr_busy, (c < 3));
      if (c == 2) begin chk("raw_nce0", nce0, 2'b01); chk("raw_addr0", addr0[1], 9'h008); end
      if (c == 4) chk("raw_valid_early", cr_valid, 0);
      if (c == 5) begin chk("raw_valid", cr_valid, 1); chk("raw_data", cr_data, 32'h1234_5678); end
    end

    // same-cycle MC write + load, MC reads, partial mask
    nxt(); idle_in(); mc_ce = 1'b0; mc_we = 1'b0; mc_wm = 4'hF; mc_addr = 10'h040; mc_data = 32'hAAAA_5555;
    cr_en = 1'b1; cr_addr = 10'h040; #2;
    chk("wr_ld_busy", cr_busy, 0);
    nxt(); idle_in(); mc_ce = 1'b0; mc_we = 1'b1; mc_addr = 10'h040; #2;
    chk("mcr_rvalid0", mc_rvalid, 0);
    nxt(); idle_in(); mc_ce = 1'b0; mc_we = 1'b0; mc_wm = 4'b0011; mc_addr = 10'h042; mc_data = 32'h1234_5678; #2;
    chk("wr_ld_valid", cr_valid, 1); chk("wr_ld_pre", cr_data, initv(0, 32'h20)); chk("mcr_rvalid1", mc_rvalid, 0);
    nxt(); idle_in(); mc_ce = 1'b0; mc_we = 1'b1; mc_addr = 10'h042; #2;
    chk("mcr_rvalid2", mc_rvalid, 1); chk("mcr_data", mc_rdata, 32'hAAAA_5555);
    nxt(); idle_in(); #2;
    chk("mcr_gap", mc_rvalid, 0);
    nxt(); #2;
    chk("mask_rvalid", mc_rvalid, 1); chk("mask_data", mc_rdata, 32'h5A00_5678);

    // reset with 3 queued stores and a load in flight
    for (int c = 0; c < 4; c++) begin
      nxt(); idle_in();
      mc_ce = 1'b0; mc_we = 1'b0; mc_wm = 4'hF; mc_addr = 10'h0C0; mc_data = 32'h0;
      if (c < 3) begin cw_valid = 1'b1; cw_wm = 4'hF; cw_addr = AW'(10'h060 + 2*c); cw_data = 32'hEEEE_0000 + c; end
      if (c == 3) begin cr_en = 1'b1; cr_addr = 10'h001; end
      #2;
      if (c == 3) chk("pre_rst_count", 32'(dut.count), 3);
    end
    nxt(); rst = 1'b0; idle_in(); #2;
    wr_snap = wr_cnt;
    chk("mid_rst_count", 32'(dut.count), 0); chk("mid_rst_nce0", nce0, 2'b11);
    chk("mid_rst_cw_busy", cw_busy, 0); chk("mid_rst_cr_valid", cr_valid, 0);
    nxt(); rst = 1'b1; #2;
    chk("post_rst_inflight", cr_valid, 0);
    for (int c = 0; c < 4; c++) begin
      nxt(); #2;
      chk("post_rst_nce0", nce0, 2'b11);
    end
    chk("post_rst_writes", wr_cnt, wr_snap);
    nxt(); cr_en = 1'b1; cr_addr = 10'h060; #2;
    nxt(); cr_en = 1'b0; #2;
    nxt(); #2;
    chk("post_rst_data", cr_data, initv(0, 32'h30));

    // MC holds bank0 for 20 cycles with a store queued behind it
    head_cyc = GUARD ? 9 : 20;
    for (int c = 0; c < 22; c++) begin
      nxt(); idle_in();
      if (c < 20) begin mc_ce = 1'b0; mc_we = 1'b0; mc_wm = 4'hF; mc_addr = 10'h080; mc_data = 32'h7777_0000; end
      if (c == 0) begin cw_valid = 1'b1; cw_wm = 4'hF; cw_addr = 10'h000; cw_data = 32'h5555_AAAA; end
      #2;
      chk("stv_stall", mc_stall, (GUARD && c == 9));
      if (c == head_cyc) begin
        chk("stv_hd_addr0", addr0[0], 9'h000); chk("stv_hd_data0", data0[0], 32'h5555_AAAA);
        chk("stv_hd_nwe0", nwe0[0], 0);
      end else if (c < 20) begin
        chk("stv_mc_addr0", addr0[0], 9'h040);
      end else begin
        chk("stv_idle_nce0", nce0, 2'b11);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
